// File: rtl/axi_regs_bank.sv
// axi_regs_bank: AXI3 slave exposing NREGS 32-bit registers.
//
// Each register is one of three kinds, chosen by parameter masks:
//   plain : read/write storage with byte strobes
//   RO    : reads return the live status_in slice; writes are refused (SLVERR)
//   W1C   : sticky bits set by status_in, cleared by writing 1
//
// Read and write paths are independent FSMs.
// Each FSM has at most one transaction in flight.
// Word address = AxADDR[ADDR_BITS+1:2]. Bursts of 1..16 beats.
// INCR and WRAP both step the word address modulo 2**ADDR_BITS; FIXED holds it.
// AxSIZE, WID and WLAST are ignored. A write burst ends on its AWLEN-th beat.
//
// Handshake rule (all five channels): a transfer happens on the rising ACLK
// edge where VALID and READY are both 1. A source never drops VALID or
// changes its payload before that edge.
//
// Ports:
//   ACLK, ARESETN              clock, synchronous active-low reset
//   AR*/R*                     read address / read data channels
//   AW*/W*/B*                  write address / write data / write response
//   regs_out [32*NREGS]        stored register contents, reg i at [32*i+:32]
//   status_in[32*NREGS]        RO read data or W1C set bits, same packing
//   wr_pulse [NREGS]           one-cycle strobe after a beat writes reg i
module axi_regs_bank #(
    parameter int                NREGS     = 16,
    parameter int                ADDR_BITS = 4,
    parameter logic [NREGS-1:0]  RO_MASK   = {NREGS{1'b0}},
    parameter logic [NREGS-1:0]  W1C_MASK  = {NREGS{1'b0}}
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [31:0]           ARADDR,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [11:0]           ARID,
    input  logic [3:0]            ARLEN,
    input  logic [1:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    output logic [31:0]           RDATA,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [11:0]           RID,
    output logic                  RLAST,
    output logic [1:0]            RRESP,
    input  logic [31:0]           AWADDR,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [11:0]           AWID,
    input  logic [3:0]            AWLEN,
    input  logic [1:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic [31:0]           WDATA,
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic [11:0]           WID,
    input  logic                  WLAST,
    input  logic [3:0]            WSTRB,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [11:0]           BID,
    output logic [1:0]            BRESP,
    output logic [32*NREGS-1:0]   regs_out,
    input  logic [32*NREGS-1:0]   status_in,
    output logic [NREGS-1:0]      wr_pulse
);

    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;
    typedef enum logic [1:0] {W_ADDR, W_DATA, W_RESP} w_state_t;

    // Inputs the protocol carries but this slave does not need.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, ARSIZE, AWSIZE, WID, WLAST,
                             ARADDR[31:ADDR_BITS+2], ARADDR[1:0],
                             AWADDR[31:ADDR_BITS+2], AWADDR[1:0]};

    // Burst address step. FIXED holds the address; every other burst type
    // increments and wraps naturally at 2**ADDR_BITS.
    function automatic logic [ADDR_BITS-1:0] next_addr(input logic [ADDR_BITS-1:0] a,
                                                       input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + ADDR_BITS'(1);
    endfunction

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    r_state_t             r_state, r_state_nxt;
    logic [ADDR_BITS-1:0] r_addr;
    logic [11:0]          r_id;
    logic [3:0]           r_len, r_cnt;
    logic [1:0]           r_burst;
    logic [31:0]          r_data;
    logic [1:0]           r_resp;
    logic                 ar_hs, r_hs, r_advance;
    logic [ADDR_BITS-1:0] rd_sel;
    logic [31:0]          rd_word;
    logic                 rd_err;

    always_comb begin
        r_state_nxt = r_state;
        ARREADY     = 1'b0;
        RVALID      = 1'b0;
        case (r_state)
            R_IDLE: begin
                ARREADY = 1'b1;
                if (ARVALID) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                RVALID = 1'b1;
                if (RREADY && (r_cnt == r_len)) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    assign ar_hs     = ARVALID & ARREADY;
    assign r_hs      = RVALID & RREADY;
    assign RLAST     = RVALID & (r_cnt == r_len);
    assign r_advance = r_hs & ~RLAST;

    // Word for the beat about to be presented.
    // The first beat takes its address from ARADDR. Later beats take the
    // stepped address.
    assign rd_sel = ar_hs ? ARADDR[ADDR_BITS+1:2] : next_addr(r_addr, r_burst);
    assign rd_err = 32'(rd_sel) >= 32'(NREGS);

    // The read word is registered when the beat is launched. It therefore
    // holds still while the master stalls. A write to the same register in
    // the same cycle is seen only by later beats.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rd_sel == ADDR_BITS'(i))
                rd_word = RO_MASK[i] ? status_in[32*i +: 32] : regs_out[32*i +: 32];
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_burst <= '0;
            r_data  <= '0;
            r_resp  <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) begin
                r_id    <= ARID;
                r_len   <= ARLEN;
                r_burst <= ARBURST;
                r_cnt   <= '0;
            end else if (r_advance) begin
                r_cnt   <= r_cnt + 4'd1;
            end
            if (ar_hs || r_advance) begin
                r_addr <= rd_sel;
                r_data <= rd_word;
                r_resp <= rd_err ? 2'b10 : 2'b00;
            end
        end
    end

    assign RDATA = r_data;
    assign RRESP = r_resp;
    assign RID   = r_id;

    // ------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------
    w_state_t             w_state, w_state_nxt;
    logic [ADDR_BITS-1:0] w_addr;
    logic [11:0]          w_id;
    logic [3:0]           w_len, w_cnt;
    logic [1:0]           w_burst;
    logic                 w_err;
    logic                 aw_hs, w_beat, w_beat_err;
    logic [NREGS-1:0]     w_hit;
    logic [31:0]          strb_mask;

    always_comb begin
        w_state_nxt = w_state;
        AWREADY     = 1'b0;
        WREADY      = 1'b0;
        BVALID      = 1'b0;
        case (w_state)
            W_ADDR: begin
                AWREADY = 1'b1;
                if (AWVALID) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                WREADY = 1'b1;
                if (WVALID && (w_cnt == w_len)) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                BVALID = 1'b1;
                if (BREADY) w_state_nxt = W_ADDR;
            end
            default: w_state_nxt = W_ADDR;
        endcase
    end

    assign aw_hs     = AWVALID & AWREADY;
    assign w_beat    = WVALID & WREADY;
    assign strb_mask = {{8{WSTRB[3]}}, {8{WSTRB[2]}}, {8{WSTRB[1]}}, {8{WSTRB[0]}}};

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NREGS; i++) w_hit[i] = (w_addr == ADDR_BITS'(i));
    end

    // A beat is an error if its word is out of range or is a read-only register.
    assign w_beat_err = (32'(w_addr) >= 32'(NREGS)) || ((w_hit & RO_MASK) != '0);

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state <= W_ADDR;
            w_addr  <= '0;
            w_id    <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) begin
                w_addr  <= AWADDR[ADDR_BITS+1:2];
                w_id    <= AWID;
                w_len   <= AWLEN;
                w_burst <= AWBURST;
                w_cnt   <= '0;
                w_err   <= 1'b0;
            end else if (w_beat) begin
                w_addr  <= next_addr(w_addr, w_burst);
                w_cnt   <= w_cnt + 4'd1;
                w_err   <= w_err | w_beat_err;
            end
        end
    end

    assign BID   = w_id;
    assign BRESP = w_err ? 2'b10 : 2'b00;

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        logic [31:0] q;
        logic        pulse_q;
        logic        hit;
        assign hit = w_beat & w_hit[i];

        always_ff @(posedge ACLK) begin
            if (!ARESETN) begin
                q       <= '0;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= hit && !RO_MASK[i] && (WSTRB != 4'b0000);
                if (RO_MASK[i]) begin
                    q <= '0;
                end else if (W1C_MASK[i]) begin
                    // Set is OR-ed in after the clear, so a set wins over a
                    // clear of the same bit in the same cycle.
                    q <= (q & ~(hit ? (WDATA & strb_mask) : 32'h0)) | status_in[32*i +: 32];
                end else if (hit) begin
                    q <= (q & ~strb_mask) | (WDATA & strb_mask);
                end
            end
        end

        assign regs_out[32*i +: 32] = q;
        assign wr_pulse[i]          = pulse_q;
    end

endmodule

// File: doc/axi_regs_bank.md
AXI_REGS_BANK -- requirements
Module: axi_regs_bank

Interface
REQ-001 SHALL have parameter NREGS, default 16, number of 32-bit registers (1..2**ADDR_BITS).
REQ-002 SHALL have parameter ADDR_BITS, default 4, word-address width, decoded from AxADDR[ADDR_BITS+1:2].
REQ-003 SHALL have parameter RO_MASK, default {NREGS{1'b0}}, bit i=1 makes register i read-only status.
REQ-004 SHALL have parameter W1C_MASK, default {NREGS{1'b0}}, bit i=1 makes register i sticky write-1-to-clear.
REQ-005 SHALL have ports, in this order:
- ACLK  in  1  sole clock, all logic on rising edge.
- ARESETN  in  1  reset, synchronous, active-low.
- ARADDR/ARVALID/ARREADY/ARID/ARLEN/ARSIZE/ARBURST  in/in/out/in/in/in/in  32/1/1/12/4/2/2  read address channel.
- RDATA/RVALID/RREADY/RID/RLAST/RRESP  out/out/in/out/out/out  32/1/1/12/1/2  read data channel.
- AWADDR/AWVALID/AWREADY/AWID/AWLEN/AWSIZE/AWBURST  in/in/out/in/in/in/in  32/1/1/12/4/2/2  write address channel.
- WDATA/WVALID/WREADY/WID/WLAST/WSTRB  in/in/out/in/in/in  32/1/1/12/1/4  write data channel.
- BVALID/BREADY/BID/BRESP  out/in/out/out  1/1/12/2  write response channel.
- regs_out  out  32*NREGS  register contents, register i at [32*i+31:32*i].
- status_in  in  32*NREGS  RO data (RO_MASK) or sticky set bits (W1C_MASK), same packing.
- wr_pulse  out  NREGS  one-cycle strobe per written register.

Function
REQ-006 Read FSM SHALL have states R_IDLE, R_DATA; ARREADY=1 only in R_IDLE.
REQ-007 On ARVALID&ARREADY SHALL capture address, ARID, ARLEN, ARBURST and enter R_DATA the next cycle with RVALID=1, RDATA valid (1-cycle latency).
REQ-008 In R_DATA, on RVALID&RREADY SHALL advance beat counter and address; RLAST=1 when counter==captured ARLEN; on last handshake return to R_IDLE (ARREADY=1 the following cycle); RDATA/RLAST/RRESP SHALL stay stable while RVALID&~RREADY.
REQ-009 Write FSM SHALL have states W_ADDR (AWREADY=1), W_DATA (WREADY=1), W_RESP (BVALID=1); read and write FSMs independent, each one transaction outstanding.
REQ-010 Each W_DATA beat handshake SHALL update addressed register bytes where WSTRB[k]=1; burst ends on beat count==AWLEN, WLAST ignored; then W_RESP until BREADY, then W_ADDR.
REQ-011 Burst address: INCR and WRAP SHALL increment word address by 1 modulo 2**ADDR_BITS; FIXED SHALL hold it; ARSIZE/AWSIZE ignored (32-bit assumed).
REQ-012 Read data: RO register SHALL return status_in slice live; others return stored value; address >= NREGS returns 0.
REQ-013 Plain register: written bytes take WDATA; regs_out reflects new value the cycle after the beat.
REQ-014 W1C register: every cycle reg <= (reg & ~clr) | status_in slice, clr = WDATA bits in strobed bytes on a write beat; simultaneous set and clear of a bit SHALL leave it 1.
REQ-015 RO register write SHALL not change state; wr_pulse still not asserted.
REQ-016 wr_pulse[i] SHALL be 1 for exactly the cycle after a beat to writable register i with WSTRB!=0.
REQ-017 RRESP per beat, BRESP per burst: 2'b10 (SLVERR) if any beat addressed >= NREGS or (write) an RO register, else 2'b00; RID=captured ARID, BID=captured AWID.
REQ-018 Concurrent read and write of same register in one cycle SHALL return the pre-write value.

Reset
REQ-019 ARESETN=0 at a rising edge SHALL force: both FSMs idle, ARREADY=1, AWREADY=1, WREADY=0, RVALID=0, BVALID=0, RLAST=0, RRESP=BRESP=0, all registers 0, wr_pulse=0, beat counters 0.
REQ-020 Reset mid-burst SHALL abandon the transaction with no response; ARREADY/AWREADY=1 the first cycle after release.

Verification
REQ-021 Write 0xDEADBEEF to reg 3, WSTRB=4'b0101 after reset -> regs_out reg3=0x00AD00EF, wr_pulse[3] one cycle, BRESP=0, BID=AWID.
REQ-022 INCR read ARADDR=0x38, ARLEN=3, NREGS=16 -> beats return regs 14,15,0,1, RLAST on beat 4 only, RRESP=0.
REQ-023 W1C reg 2: status_in bit0 pulsed -> reads 0x1; write 0x1 same cycle as another bit0 pulse -> stays 1; write 0x1 without pulse -> 0.
REQ-024 NREGS=10, write to word 12 -> no register changes, BRESP=2'b10; read word 12 -> RDATA=0, RRESP=2'b10.
REQ-025 Hold RREADY=0 for 5 cycles in R_DATA -> RDATA/RLAST stable; ARESETN=0 mid-burst -> RVALID=0 next cycle, ARREADY=1 after release.
